// File: rtl/sad_candidate_streamer.sv
// Accumulates BLOCK_PIXELS absolute differences per search-window candidate and streams
// each saturated SAD with its {row, col} tag to the running-minimum tracker.
module sad_candidate_streamer #(
    parameter int BLOCK_PIXELS = 16,
    parameter int CNT_W        = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [15:0] win_rows,
    input  logic [15:0] win_cols,
    input  logic [7:0]  diff_in,
    input  logic        diff_valid,
    output logic        diff_ready,
    output logic        max_out,
    output logic        min_in,
    output logic [12:0] value_out,
    output logic [31:0] tag_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(BLOCK_PIXELS - 1);
    localparam logic [13:0]      SAT_MAX  = 14'd8191;

    state_t           state_q, state_d;
    logic [15:0]      rows_q, rows_d;
    logic [15:0]      cols_q, cols_d;
    logic [15:0]      row_q, row_d;
    logic [15:0]      col_q, col_d;
    logic [12:0]      acc_q, acc_d;
    logic [CNT_W-1:0] pix_q, pix_d;
    logic [12:0]      value_q, value_d;
    logic [31:0]      tag_q, tag_d;

    logic [13:0]      sum;
    logic [12:0]      sat_sum;
    logic             last_col;
    logic             last_row;

    // One extra bit catches the overflow; once saturated the sum never drops below the cap.
    assign sum      = {1'b0, acc_q} + {6'd0, diff_in};
    assign sat_sum  = (sum > SAT_MAX) ? 13'h1FFF : sum[12:0];
    assign last_col = (col_q == cols_q - 16'd1);
    assign last_row = (row_q == rows_q - 16'd1);

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        row_d      = row_q;
        col_d      = col_q;
        acc_d      = acc_q;
        pix_d      = pix_q;
        value_d    = value_q;
        tag_d      = tag_q;
        diff_ready = 1'b0;
        max_out    = 1'b0;
        min_in     = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d  = win_rows;
                    cols_d  = win_cols;
                    row_d   = 16'd0;
                    col_d   = 16'd0;
                    state_d = (win_rows == 16'd0 || win_cols == 16'd0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                max_out = 1'b1;
                acc_d   = 13'd0;
                pix_d   = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                diff_ready = 1'b1;
                if (diff_valid) begin
                    if (pix_q == LAST_PIX) begin
                        value_d = sat_sum;
                        tag_d   = {row_q, col_q};
                        state_d = S_EMIT;
                    end else begin
                        acc_d = sat_sum;
                        pix_d = pix_q + 1'b1;
                    end
                end
            end
            S_EMIT: begin
                min_in = 1'b1;
                acc_d  = 13'd0;
                pix_d  = '0;
                if (last_col) begin
                    col_d = 16'd0;
                    row_d = row_q + 16'd1;
                end else begin
                    col_d = col_q + 16'd1;
                end
                state_d = (last_row && last_col) ? S_DONE : S_ACCUM;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            rows_q  <= 16'd0;
            cols_q  <= 16'd0;
            row_q   <= 16'd0;
            col_q   <= 16'd0;
            acc_q   <= 13'd0;
            pix_q   <= '0;
            value_q <= 13'd0;
            tag_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            row_q   <= row_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            pix_q   <= pix_d;
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign value_out = value_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_sad_candidate_streamer.sv
// Randomised bench for sad_candidate_streamer; a queue-based SAD model predicts every strobe.
module tb_sad_candidate_streamer;

    localparam int BP     = 4;
    localparam int BP_SAT = 40;

    logic        clk = 1'b0;
    logic        Rst;
    logic        start;
    logic [15:0] win_rows, win_cols;
    logic [7:0]  diff_in;
    logic        diff_valid;
    logic        diff_ready, max_out, min_in, busy, done;
    logic [12:0] value_out;
    logic [31:0] tag_out;

    logic        s_start;
    logic [15:0] s_rows, s_cols;
    logic [7:0]  s_diff;
    logic        s_valid;
    logic        s_ready, s_max, s_min, s_busy, s_done;
    logic [12:0] s_value;
    logic [31:0] s_tag;

    int n_chk = 0;
    int n_bad = 0;
    int samp[$];

    always #5 clk = ~clk;

    sad_candidate_streamer #(.BLOCK_PIXELS(BP), .CNT_W(8)) u_dut (
        .Clk(clk), .Rst(Rst), .start(start), .win_rows(win_rows), .win_cols(win_cols),
        .diff_in(diff_in), .diff_valid(diff_valid), .diff_ready(diff_ready),
        .max_out(max_out), .min_in(min_in), .value_out(value_out), .tag_out(tag_out),
        .busy(busy), .done(done)
    );

    sad_candidate_streamer #(.BLOCK_PIXELS(BP_SAT), .CNT_W(8)) u_sat (
        .Clk(clk), .Rst(Rst), .start(s_start), .win_rows(s_rows), .win_cols(s_cols),
        .diff_in(s_diff), .diff_valid(s_valid), .diff_ready(s_ready),
        .max_out(s_max), .min_in(s_min), .value_out(s_value), .tag_out(s_tag),
        .busy(s_busy), .done(s_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, diff_ready}, 0);
        chk({tag, "_max"},   {31'd0, max_out}, 0);
        chk({tag, "_min"},   {31'd0, min_in}, 0);
        chk({tag, "_value"}, {19'd0, value_out}, 0);
        chk({tag, "_tag"},   tag_out, 0);
        chk({tag, "_busy"},  {31'd0, busy}, 0);
        chk({tag, "_done"},  {31'd0, done}, 0);
    endtask

    // Runs one job on u_dut over the sample stream in samp. mode: 0 valid held,
    // 1 valid on every third cycle, 2 random. start_at/rst_at inject events (-1 = none).
    task automatic run_job(input int rows, input int cols, input int mode,
                           input int start_at, input int rst_at);
        int idx = 0, n_max = 0, n_busy = 0, last_min = -1, done_cyc = -1;
        int rdy_bad = 0, both_bad = 0, ncand, s;
        logic [12:0] ov[$];
        logic [31:0] ot[$];
        bit rdy, v;
        ncand = rows * cols;
        @(negedge clk);
        win_rows = rows[15:0];
        win_cols = cols[15:0];
        start    = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == start_at) begin
                start    = 1'b1;
                win_rows = 16'd7;
                win_cols = 16'd9;
            end
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                chk_idle_outputs("rst_mid");
                Rst        = 1'b0;
                diff_valid = 1'b0;
                return;
            end
            if (cyc == rst_at) Rst = 1'b1;
            if (cyc == 0 && ncand != 0) chk("start_to_max", {31'd0, max_out}, 1);
            if (max_out) n_max++;
            if (busy) n_busy++;
            if (max_out && min_in) both_bad++;
            if ((max_out || min_in) && diff_ready) rdy_bad++;
            if (min_in) begin
                ov.push_back(value_out);
                ot.push_back(tag_out);
                last_min = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            rdy = diff_ready;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            diff_valid = v && (idx < samp.size());
            diff_in    = (idx < samp.size()) ? 8'(samp[idx]) : 8'd0;
            if (diff_valid && rdy) idx++;
        end
        diff_valid = 1'b0;
        chk("done_seen", {31'd0, done_cyc >= 0}, 1);
        chk("max_count", n_max, (ncand != 0) ? 1 : 0);
        chk("min_count", ov.size(), ncand);
        chk("both_high", both_bad, 0);
        chk("rdy_clr_emit", rdy_bad, 0);
        chk("samples_used", idx, ncand * BP);
        for (int k = 0; k < ncand && k < ov.size(); k++) begin
            s = 0;
            for (int j = 0; j < BP; j++) s += samp[k * BP + j];
            if (s > 8191) s = 8191;
            chk($sformatf("value%0d", k), {19'd0, ov[k]}, s);
            chk($sformatf("tag%0d", k), ot[k], {16'(k / cols), 16'(k % cols)});
        end
        if (ncand != 0) chk("done_lat", done_cyc - last_min, 1);
        else            chk("done_lat0", done_cyc, 0);
        if (ncand == 0)     chk("busy_cycles", n_busy, 1);
        else if (mode == 0) chk("busy_cycles", n_busy, 1 + ncand * (BP + 1) + 1);
        @(negedge clk);
        chk("post_done", {30'd0, busy, done}, 0);
    endtask

    task automatic load_basic();
        int base[16] = '{1, 2, 3, 4, 0, 0, 0, 0, 5, 5, 5, 5, 255, 1, 0, 0};
        samp.delete();
        foreach (base[i]) samp.push_back(base[i]);
    endtask

    initial begin
        int r, c, n_smin, s_val, s_tg;
        bit s_seen;
        Rst = 1'b1; start = 1'b0; win_rows = '0; win_cols = '0; diff_in = '0; diff_valid = 1'b0;
        s_start = 1'b0; s_rows = '0; s_cols = '0; s_diff = '0; s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        Rst = 1'b0;

        load_basic();
        run_job(2, 2, 0, -1, -1);
        chk("last_value", {19'd0, value_out}, 256);
        chk("last_tag", tag_out, 32'h0001_0001);

        samp.delete();
        run_job(0, 5, 0, -1, -1);

        load_basic();
        run_job(2, 2, 1, -1, -1);
        run_job(2, 2, 0, 8, -1);
        run_job(2, 2, 0, -1, 7);
        run_job(2, 2, 0, -1, -1);

        for (int t = 0; t < 4; t++) begin
            r = $urandom_range(1, 3);
            c = $urandom_range(1, 3);
            samp.delete();
            for (int i = 0; i < r * c * BP; i++) samp.push_back($urandom_range(0, 255));
            run_job(r, c, 2, -1, -1);
        end

        n_smin = 0; s_val = 0; s_tg = -1; s_seen = 0;
        @(negedge clk);
        s_rows = 16'd1; s_cols = 16'd1; s_start = 1'b1; s_diff = 8'd255; s_valid = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            s_start = 1'b0;
            if (s_min) begin
                n_smin++;
                s_val = int'(s_value);
                s_tg  = int'(s_tag);
            end
            if (s_done) begin
                s_seen = 1;
                break;
            end
        end
        s_valid = 1'b0;
        chk("sat_done", {31'd0, s_seen}, 1);
        chk("sat_min_count", n_smin, 1);
        chk("sat_value", s_val, 8191);
        chk("sat_tag", s_tg, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
